// File: rtl/reg_alloc_pkg.sv
// Shared types and width helpers for the warp register allocator / mapper.
package reg_alloc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALLOC   = 2'd1,
    ST_DEALLOC = 2'd2
  } state_e;

  // Widest chunk index the LUT entry type can carry.
  localparam int MAX_CHUNK_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [MAX_CHUNK_W-1:0] chunk;
  } lut_entry_t;

  // A chunk is two adjacent banks of one row.
  function automatic int calc_nchunk(input int rows, input int banks);
    return rows * banks / 2;
  endfunction

  // Index width with a floor of one bit so single-entry dimensions stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_alloc_map_finder.sv
// Priority encoder: lowest-index free chunk in the free map.
module free_chunk_finder
  import reg_alloc_pkg::*;
#(
  parameter int NCHUNK  = 16,
  parameter int CHUNK_W = idx_w(NCHUNK)
) (
  input  logic [NCHUNK-1:0]  free_map,
  output logic [CHUNK_W-1:0] idx,
  output logic               any_free
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx      = '0;
    any_free = |free_map;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (free_map[i]) idx = CHUNK_W'(i);
    end
  end

endmodule

// File: rtl/reg_alloc_map.sv
// Per-warp register allocation: chunk free map, warp LUT and operand lookup.
module reg_alloc_map
  import reg_alloc_pkg::*;
#(
  parameter  int NUM_WARPS     = 8,
  parameter  int REGS_PER_WARP = 8,
  parameter  int NUM_BANKS     = 4,
  parameter  int NUM_ROWS      = 8,
  localparam int NCHUNK        = calc_nchunk(NUM_ROWS, NUM_BANKS),
  localparam int WARP_W        = idx_w(NUM_WARPS),
  localparam int REG_W         = idx_w(REGS_PER_WARP),
  localparam int CHUNK_W       = idx_w(NCHUNK),
  localparam int CNT_W         = $clog2(NCHUNK) + 1,
  localparam int BANK_W        = idx_w(NUM_BANKS),
  localparam int ROW_W         = idx_w(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [WARP_W-1:0] alloc_warp,
  input  logic [REG_W:0]    alloc_nreg,
  output logic              alloc_ready,
  output logic              alloc_done,
  output logic              alloc_fail,
  input  logic              dealloc_req,
  input  logic [WARP_W-1:0] dealloc_warp,
  output logic              dealloc_done,
  output logic [CNT_W-1:0]  free_chunks,
  input  logic [WARP_W-1:0] rd_warp,
  input  logic [REG_W-1:0]  src1_reg,
  input  logic              src1_valid,
  input  logic [REG_W-1:0]  src2_reg,
  input  logic              src2_valid,
  output logic [BANK_W-1:0] src1_bank,
  output logic [ROW_W-1:0]  src1_row,
  output logic              src1_hit,
  output logic [BANK_W-1:0] src2_bank,
  output logic [ROW_W-1:0]  src2_row,
  output logic              src2_hit,
  output logic              bank_conflict,
  input  logic [WARP_W-1:0] wb_warp,
  input  logic [REG_W-1:0]  wb_reg,
  output logic [BANK_W-1:0] wb_bank,
  output logic [ROW_W-1:0]  wb_row,
  output logic              wb_hit
);

  localparam int HALF = REGS_PER_WARP / 2;
  localparam int KW   = idx_w(HALF);
  localparam int HB   = NUM_BANKS / 2;

  if (REGS_PER_WARP % 2 != 0) begin : g_odd_regs
    $error("reg_alloc_map: REGS_PER_WARP must be even");
  end
  if (NUM_BANKS % 2 != 0) begin : g_odd_banks
    $error("reg_alloc_map: NUM_BANKS must be even");
  end
  if (CHUNK_W > MAX_CHUNK_W) begin : g_wide_chunk
    $error("reg_alloc_map: chunk index exceeds lut_entry_t width");
  end

  typedef struct packed {
    logic              hit;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
  } loc_t;

  state_e              state, state_d;
  logic [WARP_W-1:0]   op_warp, op_warp_d;
  logic [KW-1:0]       cnt, cnt_d;
  logic [KW:0]         n_q, n_d;
  logic                alloc_done_d, alloc_fail_d, dealloc_done_d;
  logic                claim, do_release;
  int                  need_i;
  logic [NCHUNK-1:0]   free_map;
  logic [HALF-1:0]     lut_vld   [NUM_WARPS];
  logic [CHUNK_W-1:0]  lut_chunk [NUM_WARPS][HALF];
  logic [CHUNK_W-1:0]  find_idx;
  logic                any_free;
  loc_t                l1, l2, lw;

  free_chunk_finder #(.NCHUNK(NCHUNK), .CHUNK_W(CHUNK_W)) u_finder (
    .free_map (free_map),
    .idx      (find_idx),
    .any_free (any_free)
  );

  function automatic lut_entry_t entry_of(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    lut_entry_t    e;
    logic [KW-1:0] k;
    k       = KW'(r >> 1);
    e.valid = lut_vld[w][k];
    e.chunk = MAX_CHUNK_W'(lut_chunk[w][k]);
    return e;
  endfunction

  // Physical location of one register; a miss reports bank 0 / row 0.
  function automatic loc_t locate(input lut_entry_t e, input logic reg_lsb, input logic en);
    loc_t l;
    int   c;
    l = '0;
    c = int'(e.chunk);
    if (en && e.valid) begin
      l.hit  = 1'b1;
      l.row  = ROW_W'(c / HB);
      l.bank = BANK_W'(2 * (c % HB) + int'(reg_lsb));
    end
    return l;
  endfunction

  // Next-state and control decode; a rejected or empty alloc never leaves IDLE.
  always_comb begin
    state_d        = state;
    op_warp_d      = op_warp;
    cnt_d          = cnt;
    n_d            = n_q;
    alloc_done_d   = 1'b0;
    alloc_fail_d   = 1'b0;
    dealloc_done_d = 1'b0;
    claim          = 1'b0;
    do_release     = 1'b0;
    need_i         = (int'(alloc_nreg) + 1) / 2;
    case (state)
      ST_IDLE: begin
        if (dealloc_req) begin
          state_d   = ST_DEALLOC;
          op_warp_d = dealloc_warp;
          cnt_d     = '0;
        end else if (alloc_req) begin
          if (int'(alloc_nreg) > REGS_PER_WARP || need_i > int'(free_chunks) ||
              lut_vld[alloc_warp][0]) begin
            alloc_fail_d = 1'b1;
          end else if (need_i == 0) begin
            alloc_done_d = 1'b1;
          end else begin
            state_d   = ST_ALLOC;
            op_warp_d = alloc_warp;
            cnt_d     = '0;
            n_d       = (KW+1)'(need_i);
          end
        end
      end
      ST_ALLOC: begin
        claim = any_free;
        cnt_d = cnt + 1'b1;
        if ({1'b0, cnt} == n_q - 1'b1) begin
          state_d      = ST_IDLE;
          alloc_done_d = 1'b1;
        end
      end
      ST_DEALLOC: begin
        do_release = lut_vld[op_warp][cnt];
        cnt_d      = cnt + 1'b1;
        if (cnt == KW'(HALF - 1)) begin
          state_d        = ST_IDLE;
          dealloc_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, operation context and registered completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      op_warp      <= '0;
      cnt          <= '0;
      n_q          <= '0;
      alloc_done   <= 1'b0;
      alloc_fail   <= 1'b0;
      dealloc_done <= 1'b0;
    end else begin
      state        <= state_d;
      op_warp      <= op_warp_d;
      cnt          <= cnt_d;
      n_q          <= n_d;
      alloc_done   <= alloc_done_d;
      alloc_fail   <= alloc_fail_d;
      dealloc_done <= dealloc_done_d;
    end
  end

  // Free map, free counter and LUT valid bits: one claim or one release per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_map    <= '1;
      free_chunks <= CNT_W'(NCHUNK);
      for (int w = 0; w < NUM_WARPS; w++) lut_vld[w] <= '0;
    end else begin
      if (claim) begin
        free_map[find_idx]    <= 1'b0;
        lut_vld[op_warp][cnt] <= 1'b1;
        if (free_chunks != '0) free_chunks <= free_chunks - 1'b1;
      end
      if (do_release) begin
        free_map[lut_chunk[op_warp][cnt]] <= 1'b1;
        lut_vld[op_warp][cnt]             <= 1'b0;
        if (free_chunks != CNT_W'(NCHUNK)) free_chunks <= free_chunks + 1'b1;
      end
    end
  end

  // Chunk indices are only meaningful under a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (claim) lut_chunk[op_warp][cnt] <= find_idx;
  end

  // Combinational operand and writeback lookup from the live LUT.
  always_comb begin
    l1            = locate(entry_of(rd_warp, src1_reg), src1_reg[0], src1_valid);
    l2            = locate(entry_of(rd_warp, src2_reg), src2_reg[0], src2_valid);
    lw            = locate(entry_of(wb_warp, wb_reg), wb_reg[0], 1'b1);
    src1_hit      = l1.hit;
    src1_bank     = l1.bank;
    src1_row      = l1.row;
    src2_hit      = l2.hit;
    src2_bank     = l2.bank;
    src2_row      = l2.row;
    wb_hit        = lw.hit;
    wb_bank       = lw.bank;
    wb_row        = lw.row;
    bank_conflict = l1.hit & l2.hit & (l1.bank == l2.bank);
  end

  assign alloc_ready = (state == ST_IDLE);

endmodule

// File: doc/reg_alloc_map.md
REG_ALLOC_MAP -- requirements
Module: reg_alloc_map

Interface
REQ-001 SHALL have parameter NUM_WARPS, 8, hardware warp slots.
REQ-002 SHALL have parameter REGS_PER_WARP, 8, architectural registers per warp (even).
REQ-003 SHALL have parameter NUM_BANKS, 4, register-file banks (even).
REQ-004 SHALL have parameter NUM_ROWS, 8, rows per bank; chunk = 2 adjacent banks of one row; NCHUNK = NUM_ROWS*NUM_BANKS/2.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports alloc_req / alloc_warp / alloc_nreg  in  1 / clog2(NUM_WARPS) / clog2(REGS_PER_WARP)+1  allocation request, warp, register count.
REQ-008 SHALL have ports alloc_ready / alloc_done / alloc_fail  out  1 each  idle indicator, completion pulse, rejection pulse.
REQ-009 SHALL have ports dealloc_req / dealloc_warp  in  1 / clog2(NUM_WARPS)  warp-exit release request; dealloc_done  out  1  completion pulse.
REQ-010 SHALL have port free_chunks  out  clog2(NCHUNK)+1  count of unallocated chunks.
REQ-011 SHALL have ports rd_warp, src1/src2 {reg, valid}  in  clog2(NUM_WARPS), clog2(REGS_PER_WARP), 1  operand lookup.
REQ-012 SHALL have ports src1/src2 {bank, row, hit}  out  clog2(NUM_BANKS), clog2(NUM_ROWS), 1  physical location; bank_conflict  out  1.
REQ-013 SHALL have ports wb_warp, wb_reg  in; wb_bank, wb_row, wb_hit  out  writeback lookup, same widths.

Function
REQ-014 SHALL hold a free map (1 bit/chunk) and LUT[NUM_WARPS][REGS_PER_WARP/2] of {valid, chunk index}.
REQ-015 SHALL implement FSM IDLE, ALLOC, DEALLOC; alloc_ready = (state==IDLE).
REQ-016 IDLE: dealloc_req has priority over alloc_req when both asserted; alloc_req held, not dropped.
REQ-017 Accepted alloc: n = ceil(alloc_nreg/2) chunks; fail (1-cycle alloc_fail next cycle, stay IDLE, no state change) if alloc_nreg>REGS_PER_WARP, n>free_chunks, or LUT[warp][0].valid.
REQ-018 alloc_nreg=0: alloc_done pulses next cycle, no ALLOC state entered.
REQ-019 ALLOC: each cycle claim the lowest-index free chunk into LUT[warp][k], k from 0; after n cycles return to IDLE; alloc_done pulses the cycle after the last claim (latency n+1).
REQ-020 DEALLOC: one LUT entry per cycle for REGS_PER_WARP/2 cycles; valid entries cleared and their chunk freed; invalid skipped; dealloc_done pulses the cycle after the last entry.
REQ-021 free_chunks SHALL be a registered counter, decremented per claim, incremented per release, never wrapping.
REQ-022 Lookup combinational from current LUT: entry=LUT[warp][reg>>1]; row=chunk/(NUM_BANKS/2); bank=2*(chunk mod NUM_BANKS/2)+reg[0]; hit=entry.valid.
REQ-023 hit=0 SHALL force bank=0,row=0; srcN valid low forces srcN_hit=0.
REQ-024 bank_conflict = src1_hit & src2_hit & src1_bank==src2_bank.
REQ-025 Lookups of a warp in ALLOC/DEALLOC SHALL reflect per-cycle partial LUT contents (no bypass).
REQ-026 alloc_done, alloc_fail, dealloc_done SHALL be single-cycle registered pulses, mutually exclusive.

Reset
REQ-027 rst low SHALL asynchronously force state=IDLE, free map all-free, all LUT valid=0, free_chunks=NCHUNK, pulses=0.
REQ-028 Reset mid-ALLOC/DEALLOC SHALL abandon the operation with no done pulse; post-reset state is REQ-027.

Structure
REQ-029 Package reg_alloc_pkg SHALL hold state encoding, LUT entry type, derived widths (NCHUNK, index widths).
REQ-030 Sub-module free_chunk_finder SHALL return lowest free chunk index plus any_free from the free map.
REQ-031 Elaboration SHALL error if REGS_PER_WARP or NUM_BANKS is odd.

Verification
REQ-032 Defaults, alloc warp 3 nreg=5 -> 3 chunks 0,1,2, alloc_done at cycle 4, free_chunks 16->13.
REQ-033 After REQ-032, rd_warp=3 src1=4 src2=5 -> row 1, banks 0 and 1, hits=1, bank_conflict=0; src2=0 -> banks 0/0, bank_conflict=1.
REQ-034 Fill 16 chunks with 4 warps of 8, then alloc warp 4 nreg=2 -> alloc_fail, free map unchanged.
REQ-035 Simultaneous dealloc warp 1 and alloc warp 5 -> dealloc first (done after 5 cycles), then alloc reuses warp 1's chunks lowest-first.
REQ-036 Assert rst during cycle 2 of ALLOC -> no alloc_done, free_chunks=16, all hits=0.
REQ-037 Alloc on already-valid warp, and nreg=9 -> alloc_fail each; nreg=0 -> alloc_done next cycle.
